// File: rtl/fft_frame_ctrl_if.sv
// Bundle of the signals between fft_frame_ctrl and its surroundings: the
// CPU-side sample stream, the downstream combinational fft unit, the output
// element stream and the status flags. The controller takes the slave view;
// whatever drives it (CPU datapath, fft unit, consumer) takes the master view.
interface fft_frame_ctrl_if;
    logic        start;
    logic [18:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [18:0] fft_a;
    logic        fft_en;
    logic [18:0] fft_result;
    logic [18:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [18:0] peak;
    logic        busy;
    logic        done;

    modport master (
        output start, in_data, in_valid, out_ready, fft_result,
        input  in_ready, fft_a, fft_en, out_data, out_valid, out_last,
               peak, busy, done
    );

    modport slave (
        input  start, in_data, in_valid, out_ready, fft_result,
        output in_ready, fft_a, fft_en, out_data, out_valid, out_last,
               peak, busy, done
    );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Frame controller around a combinational fft unit. A frame of FRAME_LEN
// samples is loaded from the CPU, streamed one sample per cycle through the
// fft unit while the largest magnitude is tracked, and the returned
// magnitudes are then drained in order through a valid/ready output.
// FRAME_LEN must be a power of two between 2 and 64.
module fft_frame_ctrl #(
    parameter int FRAME_LEN = 8
) (
    input logic             clk,
    input logic             rst,
    fft_frame_ctrl_if.slave bus
);

    localparam int              IW       = $clog2(FRAME_LEN);
    localparam logic [IW-1:0]   LAST_IDX = IW'(FRAME_LEN - 1);
    localparam logic [IW-1:0]   IDX_ONE  = IW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        PROC  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state;
    // One index serves as write index in LOAD, operand index in PROC and
    // read index in DRAIN; it always returns to 0 when a phase completes.
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_inc;
    logic          idx_is_last;

    logic [18:0] sample_buf [FRAME_LEN];
    logic [18:0] result_buf [FRAME_LEN];

    logic load_fire;
    logic drain_fire;

    assign idx_inc     = idx + IDX_ONE;
    assign idx_is_last = (idx == LAST_IDX);
    assign load_fire   = (state == LOAD) && bus.in_valid;
    assign drain_fire  = (state == DRAIN) && bus.out_valid && bus.out_ready;

    // Status decoded straight from the state register so that reset forces
    // them low in the same cycle it is asserted.
    assign bus.in_ready = (state == LOAD);
    assign bus.busy     = (state != IDLE);

    // Sample and result storage.
    // NOTE: the buffers have no reset on purpose; the FSM only reads entries
    // that were written earlier in the same frame, so stale contents left by
    // a reset can never reach an output.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            sample_buf[idx] <= bus.in_data;
        end
        if (state == PROC) begin
            result_buf[idx] <= bus.fft_result;
        end
    end

    // Frame sequencing with all datapath outputs registered.
    // NOTE: every assignment in this clocked block is non-blocking so each
    // register sees the pre-edge value of every other one, which is what the
    // idx / buffer read pairs below rely on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            bus.fft_a     <= '0;
            bus.fft_en    <= 1'b0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.peak      <= '0;
            bus.done      <= 1'b0;
        end else begin
            bus.done <= 1'b0;

            case (state)
                IDLE: begin
                    idx <= '0;
                    if (bus.start) begin
                        state <= LOAD;
                    end
                end

                LOAD: begin
                    if (load_fire) begin
                        idx <= idx_inc;
                        if (idx_is_last) begin
                            // Entry 0 was written on the first accept, so
                            // the first operand can be presented right away.
                            state      <= PROC;
                            bus.fft_en <= 1'b1;
                            bus.fft_a  <= sample_buf[0];
                            bus.peak   <= '0;
                        end
                    end
                end

                PROC: begin
                    idx <= idx_inc;
                    if (bus.fft_result > bus.peak) begin
                        bus.peak <= bus.fft_result;
                    end
                    if (idx_is_last) begin
                        // Entry 0 of the results is already stored, so the
                        // first output element is valid on the next cycle.
                        state         <= DRAIN;
                        bus.fft_en    <= 1'b0;
                        bus.fft_a     <= '0;
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= result_buf[0];
                        bus.out_last  <= 1'b0;
                    end else begin
                        bus.fft_a <= sample_buf[idx_inc];
                    end
                end

                DRAIN: begin
                    // Without a handshake nothing changes, which keeps
                    // out_data/out_valid/out_last stable under back-pressure.
                    if (drain_fire) begin
                        idx <= idx_inc;
                        if (idx_is_last) begin
                            state         <= IDLE;
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                            bus.out_data  <= '0;
                            bus.done      <= 1'b1;
                        end else begin
                            bus.out_data <= result_buf[idx_inc];
                            bus.out_last <= (idx_inc == LAST_IDX);
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl (FRAME_LEN = 8) with a behavioural
// model of the combinational fft unit. Loader tasks push the hand-computed
// output elements into a queue; an independent monitor pops and compares on
// every output handshake.
module tb_fft_frame_ctrl;

    typedef struct {
        logic [18:0] data;
        logic        last;
    } exp_t;

    logic clk;
    logic rst;

    fft_frame_ctrl_if bus ();

    fft_frame_ctrl #(.FRAME_LEN(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural fft unit: magnitude lookup for the operands used here.
    function automatic logic [18:0] fft_model(input logic [18:0] a);
        case (a)
            19'd0:   fft_model = 19'd0;
            19'd1:   fft_model = 19'd0;
            19'd2:   fft_model = 19'd2;
            19'd3:   fft_model = 19'd2;
            19'd4:   fft_model = 19'd5;
            19'd5:   fft_model = 19'd4;
            19'd6:   fft_model = 19'd6;
            19'd7:   fft_model = 19'd5;
            19'd8:   fft_model = 19'd8;
            default: fft_model = a ^ 19'h00003;
        endcase
    endfunction

    assign bus.fft_result = fft_model(bus.fft_a);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    exp_t exp_q[$];
    int   n_popped = 0;
    int   en_cnt   = 0;

    logic [18:0] sv [8];
    logic [18:0] ev [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: compares on each output handshake.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'(bus.out_data), 32'h7fffffff);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data", 32'(bus.out_data), 32'(e.data));
                check("out_last", 32'(bus.out_last), 32'(e.last));
                n_popped++;
            end
        end
    end

    // fft port activity: count enabled cycles and require a zero operand
    // whenever the enable is low.
    always @(negedge clk) begin
        if (bus.fft_en) begin
            en_cnt++;
        end else if (!rst) begin
            check("fft_a_idle_zero", 32'(bus.fft_a), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
        check({tag, "_fft_en"},    32'(bus.fft_en),    32'd0);
        check({tag, "_fft_a"},     32'(bus.fft_a),     32'd0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_last"},  32'(bus.out_last),  32'd0);
        check({tag, "_out_data"},  32'(bus.out_data),  32'd0);
        check({tag, "_peak"},      32'(bus.peak),      32'd0);
        check({tag, "_busy"},      32'(bus.busy),      32'd0);
        check({tag, "_done"},      32'(bus.done),      32'd0);
    endtask

    // Starts a frame and feeds sv[]; ev[] holds the expected elements.
    // Returns at #1 after the edge that accepted the last sample.
    task automatic load_frame(input bit gap, input bit poke_start);
        int i;
        int cyc;
        bit accepted;
        en_cnt   = 0;
        n_popped = 0;
        for (int k = 0; k < 8; k++) begin
            exp_t e;
            e.data = ev[k];
            e.last = (k == 7);
            exp_q.push_back(e);
        end
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("load_in_ready", 32'(bus.in_ready), 32'd1);
        check("load_busy", 32'(bus.busy), 32'd1);
        i   = 0;
        cyc = 0;
        while (i < 8 && cyc < 100) begin
            if (gap && (cyc % 2 == 1)) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 19'h1abcd;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = sv[i];
            end
            bus.start = (poke_start && i == 3) ? 1'b1 : 1'b0;
            @(negedge clk);
            accepted = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            cyc++;
            if (accepted) i++;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 19'd0;
        bus.start    = 1'b0;
        if (i < 8) check("load_timeout", 32'(i), 32'd8);
        check("proc_entry_fft_en", 32'(bus.fft_en), 32'd1);
        check("proc_entry_fft_a", 32'(bus.fft_a), 32'(sv[0]));
        check("proc_in_ready", 32'(bus.in_ready), 32'd0);
    endtask

    // Waits for the frame to drain, optionally stalling the consumer on
    // element stall_at or poking start/in_valid while draining.
    task automatic run_drain(input int stall_at, input bit poke, input logic [18:0] exp_peak);
        bit seen;
        bit stalled;
        bit poked;
        logic [18:0] held;
        seen    = 0;
        stalled = 0;
        poked   = 0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
            @(posedge clk); #1;
            if (!stalled && stall_at >= 0 && bus.out_valid && n_popped == stall_at) begin
                stalled = 1;
                held = bus.out_data;
                bus.out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_out_valid", 32'(bus.out_valid), 32'd1);
                    check("stall_out_data", 32'(bus.out_data), 32'(held));
                    @(posedge clk); #1;
                end
                bus.out_ready = 1'b1;
            end
            if (poke && !poked && bus.out_valid && n_popped == 2) begin
                poked = 1;
                bus.start    = 1'b1;
                bus.in_valid = 1'b1;
                bus.in_data  = 19'h7ffff;
                @(negedge clk);
                check("drain_in_ready", 32'(bus.in_ready), 32'd0);
                check("drain_busy", 32'(bus.busy), 32'd1);
                @(posedge clk); #1;
                bus.start    = 1'b0;
                bus.in_valid = 1'b0;
                bus.in_data  = 19'd0;
            end
            if (bus.done) begin
                seen = 1;
                check("done_out_valid", 32'(bus.out_valid), 32'd0);
                check("done_busy", 32'(bus.busy), 32'd0);
                check("peak", 32'(bus.peak), 32'(exp_peak));
                check("elements_drained", 32'(n_popped), 32'd8);
                check("proc_cycles", 32'(en_cnt), 32'd8);
                @(posedge clk); #1;
                check("done_one_cycle", 32'(bus.done), 32'd0);
                check("peak_hold", 32'(bus.peak), 32'(exp_peak));
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.in_data   = 19'd0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Ramp 0..7 back to back.
        sv = '{19'd0, 19'd1, 19'd2, 19'd3, 19'd4, 19'd5, 19'd6, 19'd7};
        ev = '{19'd0, 19'd0, 19'd2, 19'd2, 19'd5, 19'd4, 19'd6, 19'd5};
        load_frame(1'b0, 1'b0);
        run_drain(-1, 1'b0, 19'd6);

        // Alternating 8,3.
        sv = '{19'd8, 19'd3, 19'd8, 19'd3, 19'd8, 19'd3, 19'd8, 19'd3};
        ev = '{19'd8, 19'd2, 19'd8, 19'd2, 19'd8, 19'd2, 19'd8, 19'd2};
        load_frame(1'b0, 1'b0);
        run_drain(-1, 1'b0, 19'd8);

        // Descending ramp with in_valid toggling every other cycle.
        sv = '{19'd7, 19'd6, 19'd5, 19'd4, 19'd3, 19'd2, 19'd1, 19'd0};
        ev = '{19'd5, 19'd6, 19'd4, 19'd5, 19'd2, 19'd2, 19'd0, 19'd0};
        load_frame(1'b1, 1'b0);
        run_drain(-1, 1'b0, 19'd6);

        // Consumer stalls for three cycles on element 4.
        sv = '{19'd1, 19'd2, 19'd3, 19'd4, 19'd5, 19'd6, 19'd7, 19'd8};
        ev = '{19'd0, 19'd2, 19'd2, 19'd5, 19'd4, 19'd6, 19'd5, 19'd8};
        load_frame(1'b0, 1'b0);
        run_drain(4, 1'b0, 19'd8);

        // Reset on PROC cycle 3 abandons the frame.
        sv = '{19'd8, 19'd8, 19'd8, 19'd8, 19'd8, 19'd8, 19'd8, 19'd8};
        ev = '{19'd8, 19'd8, 19'd8, 19'd8, 19'd8, 19'd8, 19'd8, 19'd8};
        load_frame(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("mid_proc_reset");
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("post_reset_no_output", 32'(bus.out_valid), 32'd0);
        check("post_reset_idle", 32'(bus.busy), 32'd0);

        // Fresh frame after the reset.
        sv = '{19'd4, 19'd4, 19'd6, 19'd6, 19'd0, 19'd0, 19'd2, 19'd2};
        ev = '{19'd5, 19'd5, 19'd6, 19'd6, 19'd0, 19'd0, 19'd2, 19'd2};
        load_frame(1'b0, 1'b0);
        run_drain(-1, 1'b0, 19'd6);

        // start pulsed during LOAD and DRAIN, in_valid during DRAIN.
        sv = '{19'd5, 19'd0, 19'd8, 19'd1, 19'd6, 19'd2, 19'd7, 19'd3};
        ev = '{19'd4, 19'd0, 19'd8, 19'd0, 19'd6, 19'd2, 19'd5, 19'd2};
        load_frame(1'b0, 1'b1);
        run_drain(-1, 1'b1, 19'd8);
        repeat (3) @(posedge clk);
        #1;
        check("ignored_start_stays_idle", 32'(bus.busy), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 Parameter: FRAME_LEN, default 8, number of 19-bit samples per frame; legal values are powers of two from 2 to 64.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  begin a new frame; sampled only in IDLE.
REQ-005 in_data  input  19  sample from CPU datapath.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 fft_a  output  19  operand to downstream combinational fft unit (port a).
REQ-009 fft_en  output  1  enable to fft unit.
REQ-010 fft_result  input  19  magnitude returned by fft unit, same cycle as fft_a.
REQ-011 out_data  output  19  processed frame element.
REQ-012 out_valid  output  1  out_data valid.
REQ-013 out_ready  input  1  consumer accepts out_data.
REQ-014 out_last  output  1  marks final element of frame, qualified by out_valid.
REQ-015 peak  output  19  largest unsigned fft_result captured in current/last frame.
REQ-016 busy  output  1  high in any state except IDLE.
REQ-017 done  output  1  one-cycle pulse after final output handshake.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, PROC, DRAIN.
REQ-019 IDLE -> LOAD on start=1; start in any other state SHALL be ignored.
REQ-020 LOAD: in_ready=1; each in_valid&in_ready cycle writes in_data to sample buffer at write index, index increments; after FRAME_LEN accepts -> PROC on the next edge.
REQ-021 PROC: exactly FRAME_LEN cycles; cycle i drives fft_a=sample[i], fft_en=1; fft_result captured into result[i] at end of that cycle.
REQ-022 Outside PROC, fft_en SHALL be 0 and fft_a SHALL be 19'd0.
REQ-023 peak SHALL clear to 0 on entry to PROC and update to max(peak, fft_result) (unsigned) each PROC cycle; it holds after PROC until the next frame.
REQ-024 PROC -> DRAIN after cycle FRAME_LEN-1; out_valid SHALL first assert the cycle after the last PROC cycle.
REQ-025 DRAIN: out_data=result[read index], out_valid=1; index advances only on out_valid&out_ready; out_data/out_valid SHALL be held stable while out_ready=0.
REQ-026 out_last=1 exactly when read index = FRAME_LEN-1 in DRAIN.
REQ-027 Final handshake -> IDLE and done=1 for one cycle; out_valid=0 in that cycle.
REQ-028 in_ready=0 in PROC, DRAIN, IDLE; input data presented then SHALL be discarded, not buffered.
REQ-029 Indices are log2(FRAME_LEN) bits, wrap to 0 on frame completion; no partial frames.
REQ-030 No data path arithmetic other than the peak comparison; results pass through unchanged.

Reset
REQ-031 rst=1 SHALL immediately force IDLE, indices 0, in_ready=0, fft_en=0, fft_a=0, out_valid=0, out_last=0, out_data=0, peak=0, busy=0, done=0.
REQ-032 Reset mid-frame SHALL abandon the frame; buffer contents need not be cleared but SHALL never be output without a fresh LOAD.

Verification (fft_frame_ctrl wired to the real fft unit, FRAME_LEN=8)
REQ-033 Load samples 0..7 back-to-back, out_ready=1 -> outputs 0,0,2,2,5,4,6,5; out_last on 8th; peak=6; done pulse 1 cycle after 8th handshake.
REQ-034 Samples 8,3 repeated ×4 -> outputs 8,2,8,2,8,2,8,2; peak=8; PROC lasts exactly 8 cycles with fft_en=1.
REQ-035 in_valid toggled every other cycle during LOAD -> PROC starts one edge after 8th accept; no samples lost or duplicated.
REQ-036 out_ready low 3 cycles on element 4 -> out_data/out_valid stable, no skip; remaining order intact.
REQ-037 rst asserted on PROC cycle 3 -> all outputs at reset values same cycle; subsequent start+new frame gives correct results, no stale data.
REQ-038 start pulsed during LOAD and DRAIN -> ignored; in_valid during DRAIN -> in_ready=0, data discarded.
